// File: rtl/q_pkg.sv
// Shared types and default sizing for the Q-function sweep controller.
package q_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } q_sweep_state_t;

    localparam int unsigned Q_LATENCY = 64;
    localparam int unsigned Q_DEPTH   = 16;

endpackage

// File: rtl/q_result_fifo.sv
// Synchronous result FIFO with occupancy output; head is visible while not empty.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module q_result_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     occ_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wr_ptr_q;
    ptr_t             rd_ptr_q;
    cnt_t             cnt_q;
    logic             do_pop;
    logic             full;

    assign full    = (32'(cnt_q) == DEPTH);
    assign do_pop  = pop_i && (cnt_q != '0);
    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign occ_o   = cnt_q;

    // Storage array, written at the tail on every push.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            case ({push_i, do_pop})
                2'b10:   cnt_q <= cnt_q + cnt_t'(1);
                2'b01:   cnt_q <= cnt_q - cnt_t'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // The upstream credit scheme must never let a push land on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));

endmodule

// File: rtl/q_sweep_ctrl.sv
// Sweep controller: issues X operands to the fixed-latency Q datapath under a
// credit limit and streams the returned results out in issue order.
module q_sweep_ctrl
    import q_pkg::*;
#(
    parameter int unsigned LATENCY = Q_LATENCY,
    parameter int unsigned DEPTH   = Q_DEPTH,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          start,
    input  logic [31:0]   x_start,
    input  logic [31:0]   x_step,
    input  logic [CW-1:0] count,
    input  logic [31:0]   n_in,
    input  logic [31:0]   t_in,
    output logic [31:0]   x_out,
    output logic [31:0]   n_out,
    output logic [31:0]   t_out,
    input  logic [31:0]   q_in,
    output logic [31:0]   m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          busy,
    output logic          done
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] cnt_t;

    q_sweep_state_t     state_q, state_d;
    logic [31:0]        x_cur_q, x_cur_d;
    logic [31:0]        step_q, step_d;
    logic [CW-1:0]      rem_q, rem_d;
    logic [31:0]        n_q, n_d;
    logic [31:0]        t_q, t_d;
    logic [LATENCY-1:0] dl_q, dl_d;
    cnt_t               infl_q, infl_d;
    cnt_t               occ;
    logic               issue;
    logic               capture;
    logic               credit;

    assign capture = dl_q[LATENCY-1];
    assign credit  = (32'(infl_q) + 32'(occ)) < DEPTH;

    // Next-state, operand sequencing, delay line and in-flight credit accounting.
    // x_cur is what x_out presents; it is not advanced on the final issue so the
    // last operand stays on the bus instead of a value one step past the sweep.
    always_comb begin
        state_d = state_q;
        x_cur_d = x_cur_q;
        step_d  = step_q;
        rem_d   = rem_q;
        n_d     = n_q;
        t_d     = t_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_cur_d = x_start;
                    step_d  = x_step;
                    rem_d   = count;
                    n_d     = n_in;
                    t_d     = t_in;
                    state_d = (count != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    rem_d = rem_q - CW'(1);
                    if (rem_q != CW'(1)) begin
                        x_cur_d = x_cur_q + step_q;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((dl_q == '0) && !m_tvalid) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        dl_d    = dl_q << 1;
        dl_d[0] = issue;

        case ({issue, capture})
            2'b10:   infl_d = infl_q + cnt_t'(1);
            2'b01:   infl_d = infl_q - cnt_t'(1);
            default: infl_d = infl_q;
        endcase
    end

    // State and datapath registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            x_cur_q <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            n_q     <= '0;
            t_q     <= '0;
            dl_q    <= '0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            x_cur_q <= x_cur_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            n_q     <= n_d;
            t_q     <= t_d;
            dl_q    <= dl_d;
            infl_q  <= infl_d;
        end
    end

    assign x_out = x_cur_q;
    assign n_out = n_q;
    assign t_out = t_q;
    assign busy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done  = (state_q == ST_DONE);

    q_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (aresetn),
        .push_i  (capture),
        .data_i  (q_in),
        .pop_i   (m_tready),
        .data_o  (m_tdata),
        .valid_o (m_tvalid),
        .occ_o   (occ)
    );

endmodule

// File: doc/q_sweep_ctrl.md
# q_sweep_ctrl

Sweep controller that drives operand sets into the fixed-latency Q-function datapath (`q_func`) and collects its `Qfixed` results in issue order. It sits between the PS-facing control registers and the datapath on the Zybo fabric. Each sweep starts at `x_start` and advances X by `x_step` for `count` points, with N and T held constant. Results stream out on an AXI-stream master. A credit counter guarantees no result is lost, even though the datapath has no backpressure.

## Interface
Parameters:
- `LATENCY`, default 64: cycles from an operand change on `x_out` to the corresponding `q_in`. Must be ≥1.
- `DEPTH`, default 16: result FIFO entries. Must be a power of two.
- `CW`, default 16: width of `count`.

Ports:
- `clk` in 1: single clock.
- `aresetn` in 1: reset. Asynchronous assert, active-low.
- `start` in 1: one-cycle request to begin a sweep.
- `x_start` in 32: first X value.
- `x_step` in 32: X increment.
- `count` in CW: number of points.
- `n_in` in 32: N value for the sweep.
- `t_in` in 32: T value for the sweep.
- `x_out` out 32: to datapath X.
- `n_out` out 32: to datapath N.
- `t_out` out 32: to datapath T.
- `q_in` in 32: datapath `Qfixed`.
- `m_tdata` out 32: result.
- `m_tvalid` out 1: result valid.
- `m_tready` in 1: downstream ready.
- `busy` out 1: high in ISSUE and DRAIN.
- `done` out 1: one-cycle pulse at sweep end.

## Operation
- States are IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `start`=1 latches `x_start`, `x_step`, `count`, `n_in` and `t_in`.
  - `n_out` and `t_out` take the latched values.
  - Next state is ISSUE if `count`≠0, else DONE.
- **ISSUE**
  - Credit condition: in-flight count + FIFO occupancy < DEPTH.
  - When credit is available:
    - present `x_out` = x_cur;
    - shift a 1 into the valid delay line;
    - x_cur += `x_step`, modulo 2^32, wrapping silently;
    - remaining -= 1.
  - When credit is unavailable, shift in a 0 and hold `x_out`.
  - When remaining reaches 0, go to DRAIN.
- **DRAIN**
  - No issues.
  - Leave for DONE when the delay line is all-zero and the FIFO is empty.
- **DONE**
  - `done`=1 for exactly one cycle.
  - Next state is IDLE.
- Capture: when the delay-line output is 1, push `q_in` into the FIFO. Cycles with a 0 output are discarded.
- FIFO output: `m_tvalid` = FIFO not empty; `m_tdata` = FIFO head. Pop occurs on `m_tvalid`&`m_tready`.
- Push and pop may occur in the same cycle. Credit accounting prevents overflow, so a push when full is a design error and is flagged by an assertion.
- `start` is ignored while `busy` or in DONE.
- `n_out` and `t_out` are held constant for the whole sweep, so the datapath sees stable N and T.

## Timing
- Reset values: `x_out`, `n_out`, `t_out`, `m_tdata`=0; `m_tvalid`, `busy`, `done`=0; state IDLE; FIFO empty; delay line cleared.
- Reset mid-sweep discards all in-flight and buffered results. Results arriving from the datapath after reset are not captured.
- `start` sampled at edge k:
  - `busy`=1 from k+1;
  - first `x_out` valid from k+1.
- Operand issued at edge i: its `q_in` is captured at edge i+LATENCY, and `m_tvalid` is 1 from i+LATENCY+1.
- With `m_tready` held at 1 and no credit stall, the sweep sustains one result per cycle, provided DEPTH ≥ LATENCY+1. Otherwise throughput is limited to DEPTH results per LATENCY+1 cycles.
- `done` asserts one cycle after the last pop handshake. With `count`=0, `done` asserts at k+1.
- Outputs are registered, with no combinational path from `m_tready` to `m_tvalid`.

## Structure
- Package `q_pkg` holds:
  - the state enum `q_sweep_state_t`;
  - the default constants `Q_LATENCY`=64 and `Q_DEPTH`=16.
- Sub-module `q_result_fifo`: synchronous FIFO with DEPTH entries, 32 bits wide, with an occupancy output.
- The delay line and credit counter are written inline in `q_sweep_ctrl`.

## Test plan
The datapath model is `q_in` = `x_out` + 100, delayed by LATENCY cycles.
- **Basic sweep:** `count`=4, `x_start`=0, `x_step`=1, `m_tready`=1 → `m_tdata` 100, 101, 102, 103 in order; first `m_tvalid` at k+LATENCY+2; `done` pulse after the 4th pop.
- **Backpressure:** `count`=40, DEPTH=16, `m_tready`=0 → at most 16 issues, `x_out` stalls at 16. Release `m_tready` → all 40 results 100..139 in order, none lost or duplicated.
- **Zero count:** `count`=0 → `busy` never set; `done` pulses at k+1; no `m_tvalid`.
- **Wrap-around:** `x_start`=32'hFFFF_FFFE, `x_step`=1, `count`=3 → `x_out` FFFF_FFFE, FFFF_FFFF, 0000_0000; results wrap accordingly.
- **Reset mid-ISSUE:** deassert `aresetn` after 5 issues → all outputs 0 immediately. New sweep `count`=2 yields exactly 2 results, with no stale data.
- **Start while busy:** second `start` during ISSUE with different `x_start` → ignored; results match the first sweep only.
